// File: rtl/trace_drain_controller.sv
// rtl/trace_drain_controller.sv - buffers trace records and drains them word-by-word into a circular memory buffer
module trace_drain_controller #(
    parameter int                ADDR_WIDTH   = 32,
    parameter int                DATA_WIDTH   = 32,
    parameter int                RECORD_WIDTH = 128,
    parameter int                FIFO_DEPTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0001_0000,
    parameter int                BUF_WORDS    = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            trace_data_ready,
    input  logic [RECORD_WIDTH-1:0]         trace_record_i,
    output logic                            out_req,
    output logic [ADDR_WIDTH-1:0]           out_addr,
    output logic [DATA_WIDTH-1:0]           out_wdata,
    input  logic                            out_gnt,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [15:0]                     drop_count,
    output logic                            busy
);

    localparam int WORDS = RECORD_WIDTH / DATA_WIDTH;
    localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int LW    = PW + 1;
    localparam int WPW   = $clog2(BUF_WORDS);

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    state_t                  state, state_next;
    logic [RECORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [LW-1:0]           count, count_next;
    logic [KW-1:0]           k;
    logic [WPW-1:0]          wptr;
    logic [DATA_WIDTH-1:0]   head_words [WORDS];
    logic                    full, empty, last_word, grant, pop, push, drop;

    assign full      = (count == LW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign last_word = (k == KW'(WORDS - 1));
    assign grant     = (state == SEND) && out_gnt;
    assign pop       = grant && last_word;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign push      = trace_data_ready && (!full || pop);
    assign drop      = trace_data_ready && full && !pop;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + LW'(1);
        else if (pop && !push)
            count_next = count - LW'(1);
    end

    for (genvar i = 0; i < WORDS; i++) begin : g_words
        assign head_words[i] = mem[rd_ptr][i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= trace_record_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            k          <= '0;
            wptr       <= '0;
            drop_count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (grant) begin
                k    <= last_word ? '0 : k + KW'(1);
                wptr <= wptr + WPW'(1);
            end
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enable && !empty) state_next = SEND;
            SEND: if (pop && !(enable && count_next != '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign out_req    = (state == SEND);
    assign out_wdata  = (state == SEND) ? head_words[k] : '0;
    assign out_addr   = BASE_ADDR + ADDR_WIDTH'({wptr, 2'b00});
    assign fifo_level = count;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_trace_drain_controller.sv
// tb/tb_trace_drain_controller.sv - randomized and directed bench with a queue-based reference model
module tb_trace_drain_controller;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          RW    = 128;
    localparam int          DEPTH = 8;
    localparam int          BW    = 8;
    localparam int          WORDS = RW / DW;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          trace_data_ready = 1'b0;
    logic [RW-1:0] trace_record_i = '0;
    logic          out_gnt = 1'b0;
    logic          out_req;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_wdata;
    logic [3:0]    fifo_level;
    logic [15:0]   drop_count;
    logic          busy;

    trace_drain_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RECORD_WIDTH(RW),
        .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .BUF_WORDS(BW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .trace_data_ready(trace_data_ready), .trace_record_i(trace_record_i),
        .out_req(out_req), .out_addr(out_addr), .out_wdata(out_wdata),
        .out_gnt(out_gnt), .fifo_level(fifo_level), .drop_count(drop_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Reference model: records in flight, words granted so far, expected request line.
    logic [RW-1:0] q [$];
    logic [31:0]   addr_log [$];
    logic [RW-1:0] m_head;
    int            drops, wcount, widx, gnt_total, m_sz;
    bit            exp_req, m_pop, stall;
    logic [31:0]   p_addr, p_wdata;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            addr_log.delete();
            drops = 0; wcount = 0; widx = 0; gnt_total = 0;
            exp_req = 0; stall = 0;
        end else begin
            check("req", out_req, exp_req);
            check("busy", busy, exp_req);
            check("level", fifo_level, q.size());
            check("drops", drop_count, drops);
            if (stall && out_req) begin
                check("stall_addr", out_addr, p_addr);
                check("stall_wdata", out_wdata, p_wdata);
            end
            stall   = out_req && !out_gnt;
            p_addr  = out_addr;
            p_wdata = out_wdata;
            m_sz    = q.size();
            m_pop   = 0;
            if (exp_req && out_gnt && q.size() > 0) begin
                m_head = q[0];
                check("addr", out_addr, BASE + 32'(4 * (wcount % BW)));
                check("wdata", out_wdata, m_head[widx*DW +: DW]);
                addr_log.push_back(out_addr);
                wcount++; gnt_total++; widx++;
                if (widx == WORDS) begin
                    m_pop = 1;
                    widx  = 0;
                    void'(q.pop_front());
                end
            end
            if (trace_data_ready) begin
                if (q.size() < DEPTH) q.push_back(trace_record_i);
                else if (drops < 65535) drops++;
            end
            if (exp_req) begin
                if (m_pop) exp_req = enable && q.size() > 0;
            end else begin
                exp_req = enable && m_sz > 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; trace_data_ready = 1'b0; out_gnt = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic push(input logic [RW-1:0] rec);
        trace_data_ready = 1'b1;
        trace_record_i   = rec;
        tick(1);
        trace_data_ready = 1'b0;
    endtask

    function automatic logic [RW-1:0] rand_rec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_req();
        int i;
        for (i = 0; i < 20 && !out_req; i++) tick(1);
        check("req_timeout", out_req, 1);
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget && (busy || fifo_level != 0); i++) tick(1);
        check("drain_timeout", i < budget, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        rst = 1'b0;
        check("rst_addr", out_addr, BASE);
        check("rst_level", fifo_level, 0);
        check("rst_drops", drop_count, 0);
        check("rst_req", out_req, 0);
        check("rst_wdata", out_wdata, 0);

        // Asynchronous reset in the middle of a request
        enable = 1'b1;
        push(rand_rec());
        wait_req();
        #2 rst = 1'b1;
        #1;
        check("async_rst_req", out_req, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_addr", out_addr, BASE);
        check("async_rst_level", fifo_level, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single record, grant tied high
        do_reset();
        enable = 1'b1; out_gnt = 1'b1;
        push(128'h44444444_33333333_22222222_11111111);
        wait_drain(50);
        check("single_words", gnt_total, 4);
        check("single_addr3", addr_log[3], BASE + 32'hC);
        check("single_idle", busy, 0);

        // Grant stall on word 1
        do_reset();
        enable = 1'b1; out_gnt = 1'b0;
        push(rand_rec());
        wait_req();
        out_gnt = 1'b1;
        tick(1);
        out_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", out_req, 1);
            check("stall_word1_addr", out_addr, BASE + 32'h4);
            tick(1);
        end
        out_gnt = 1'b1;
        wait_drain(50);
        check("stall_words", gnt_total, 4);

        // Overflow
        do_reset();
        out_gnt = 1'b1;
        for (int i = 0; i < 10; i++) push(rand_rec());
        tick(1);
        check("ovf_level", fifo_level, 8);
        check("ovf_drops", drop_count, 2);
        enable = 1'b1;
        wait_drain(200);
        check("ovf_words", gnt_total, 32);
        check("ovf_drops_after", drop_count, 2);

        // Full FIFO with push on the last-word grant
        do_reset();
        for (int i = 0; i < 8; i++) push(rand_rec());
        enable = 1'b1;
        wait_req();
        out_gnt = 1'b1;
        tick(3);
        trace_data_ready = 1'b1;
        trace_record_i   = rand_rec();
        tick(1);
        trace_data_ready = 1'b0;
        out_gnt = 1'b0;
        check("full_pp_level", fifo_level, 8);
        check("full_pp_drops", drop_count, 0);
        out_gnt = 1'b1;
        wait_drain(200);
        check("full_pp_words", gnt_total, 36);

        // Address wrap with an 8-word buffer
        do_reset();
        enable = 1'b1; out_gnt = 1'b1;
        for (int i = 0; i < 3; i++) push(rand_rec());
        wait_drain(100);
        check("wrap_words", gnt_total, 12);
        check("wrap_word9", addr_log[8], BASE);
        check("wrap_word12", addr_log[11], BASE + 32'hC);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable           = ($urandom % 4) != 0;
            out_gnt          = ($urandom % 3) != 0;
            trace_data_ready = ($urandom % 3) == 0;
            trace_record_i   = rand_rec();
            tick(1);
        end
        trace_data_ready = 1'b0;
        enable = 1'b1; out_gnt = 1'b1;
        wait_drain(200);
        check("rand_final_level", fifo_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
